// File: rtl/ula_pkg.sv
// Shared types and constants for the multi-byte 74181-pair ALU controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ula_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Function selects; SUB and XOR share an encoding and differ only by mode.
    localparam logic [3:0] S_ADD = 4'b1001;  // m = 0: A plus B
    localparam logic [3:0] S_SUB = 4'b0110;  // m = 0: A minus B minus 1 (+1 with carry in)
    localparam logic [3:0] S_XOR = 4'b0110;  // m = 1: A xor B
    localparam logic [3:0] S_AND = 4'b1011;  // m = 1: A and B

    // Carry is active-low on the ALU: a 1 means no carry.
    localparam logic CARRY_NONE = 1'b1;

endpackage

// File: rtl/ula_8bits.sv
// 8-bit ALU equivalent to two cascaded 74181s (active-high data, active-low carry).
// Latency: purely combinational.
// Backpressure: none; results follow the operands in the same cycle.
// Ports: a/b operands, s function select, m mode (1 = logic), c_in carry in,
//        f result, c_out carry out, a_eq_b high when every bit of f is 1.
module ula_8bits (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [7:0] f,
    output logic       c_out,
    output logic       a_eq_b
);

    logic [7:0] term_or;
    logic [7:0] term_and;
    logic [8:0] sum;

    // The 74181 arithmetic result is (OR-term) plus (AND-term) plus carry;
    // the logic result is the carry-free combination of the same two terms.
    assign term_or  = a | (b & {8{s[0]}}) | (~b & {8{s[1]}});
    assign term_and = (a & b & {8{s[3]}}) | (a & ~b & {8{s[2]}});
    assign sum      = {1'b0, term_or} + {1'b0, term_and} + {8'b0, ~c_in};

    assign f      = m ? ~(term_or ^ term_and) : sum[7:0];
    // Carry out is produced in both modes, as on the real part.
    assign c_out  = ~sum[8];
    assign a_eq_b = &f;

endmodule

// File: rtl/ula_multibyte_ctrl.sv
// Runs N-byte operations on an 8-bit ALU, LSB first, chaining carry and AND-ing equality.
// Latency: NBYTES cycles from request accept to rsp_valid; one op per NBYTES+1 cycles peak.
// Backpressure: rsp held stable until rsp_ready; a new request is taken in DONE only with rsp_ready.
// Ports: req_* request handshake and operands; alu_* byte interface to ula_8bits;
//        rsp_* response handshake with assembled result, top carry and equality.
module ula_multibyte_ctrl
    import ula_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [8*NBYTES-1:0]   req_a,
    input  logic [8*NBYTES-1:0]   req_b,
    input  logic [3:0]            req_s,
    input  logic                  req_m,
    input  logic                  req_c_in,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic [3:0]            alu_s,
    output logic                  alu_m,
    output logic                  alu_c_in,
    input  logic [7:0]            alu_f,
    input  logic                  alu_c_out,
    input  logic                  alu_a_eq_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*NBYTES-1:0]   rsp_f,
    output logic                  rsp_c_out,
    output logic                  rsp_a_eq_b
);

    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t state;
    state_t next_state;

    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [3:0]       s_q;
    logic             m_q;
    logic             carry_q;
    logic             eq_acc_q;
    logic [IDX_W-1:0] idx_q;

    logic accept;
    logic in_run;
    logic last_byte;

    assign in_run    = (state == RUN);
    assign last_byte = in_run && (idx_q == LAST_IDX);
    assign accept    = req_valid && req_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last_byte) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                // Only take a new request once the current result is consumed.
                req_ready = rsp_ready;
                if (rsp_ready) begin
                    next_state = req_valid ? RUN : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (rst) begin
            req_ready = 1'b0;
        end
    end

    // Byte lane towards the ALU; everything is quiet outside RUN.
    assign alu_a    = in_run ? a_q[8*idx_q +: 8] : 8'h00;
    assign alu_b    = in_run ? b_q[8*idx_q +: 8] : 8'h00;
    assign alu_s    = in_run ? s_q : 4'h0;
    assign alu_m    = in_run ? m_q : 1'b0;
    assign alu_c_in = in_run ? carry_q : 1'b0;

    // Operand capture and result assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            s_q        <= 4'h0;
            m_q        <= 1'b0;
            carry_q    <= 1'b0;
            eq_acc_q   <= 1'b0;
            idx_q      <= '0;
            rsp_f      <= '0;
            rsp_c_out  <= 1'b0;
            rsp_a_eq_b <= 1'b0;
        end else if (accept) begin
            a_q      <= req_a;
            b_q      <= req_b;
            s_q      <= req_s;
            m_q      <= req_m;
            carry_q  <= req_c_in;
            eq_acc_q <= 1'b1;
            idx_q    <= '0;
            rsp_f    <= '0;
        end else if (in_run) begin
            rsp_f[8*idx_q +: 8] <= alu_f;
            carry_q             <= alu_c_out;
            eq_acc_q            <= eq_acc_q & alu_a_eq_b;
            idx_q               <= idx_q + IDX_W'(1);
            if (last_byte) begin
                rsp_c_out  <= alu_c_out;
                rsp_a_eq_b <= eq_acc_q & alu_a_eq_b;
            end
        end
    end

endmodule

// File: tb/tb_ula_multibyte_ctrl.sv
// Bench for ula_multibyte_ctrl driving a real ula_8bits with NBYTES = 4.
// Latency: checks rsp_valid appears exactly NBYTES cycles after accept.
// Backpressure: exercises held responses and same-edge DONE-to-RUN handoff.
module tb_ula_multibyte_ctrl;
    import ula_pkg::*;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [3:0]   req_s;
    logic         req_m;
    logic         req_c_in;
    logic [7:0]   alu_a;
    logic [7:0]   alu_b;
    logic [3:0]   alu_s;
    logic         alu_m;
    logic         alu_c_in;
    logic [7:0]   alu_f;
    logic         alu_c_out;
    logic         alu_a_eq_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_f;
    logic         rsp_c_out;
    logic         rsp_a_eq_b;

    always #5 clk = ~clk;

    ula_multibyte_ctrl #(.NBYTES(NB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_s      (req_s),
        .req_m      (req_m),
        .req_c_in   (req_c_in),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .alu_m      (alu_m),
        .alu_c_in   (alu_c_in),
        .alu_f      (alu_f),
        .alu_c_out  (alu_c_out),
        .alu_a_eq_b (alu_a_eq_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_f      (rsp_f),
        .rsp_c_out  (rsp_c_out),
        .rsp_a_eq_b (rsp_a_eq_b)
    );

    ula_8bits alu (
        .a      (alu_a),
        .b      (alu_b),
        .s      (alu_s),
        .m      (alu_m),
        .c_in   (alu_c_in),
        .f      (alu_f),
        .c_out  (alu_c_out),
        .a_eq_b (alu_a_eq_b)
    );

    typedef struct {
        logic [3:0]   s;
        logic         m;
        logic         c_in;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] f;
        logic         c;
        logic         eq;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc;
    } exp_t;

    exp_t sb[$];
    vec_t vt[7];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   seen     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Response monitor: latency on first sight of rsp_valid, contents on handshake.
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=valid required=idle f=%h", rsp_f);
            end else begin
                if (!seen) begin
                    chk("latency", W'(cyc - sb[0].acc), W'(NB));
                    seen = 1'b1;
                end
                if (rsp_ready) begin
                    chk("rsp_f", rsp_f, sb[0].v.f);
                    chk("rsp_c_out", W'(rsp_c_out), W'(sb[0].v.c));
                    chk("rsp_a_eq_b", W'(rsp_a_eq_b), W'(sb[0].v.eq));
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic drive_req(input vec_t v);
        req_a    = v.a;
        req_b    = v.b;
        req_s    = v.s;
        req_m    = v.m;
        req_c_in = v.c_in;
    endtask

    task automatic send(input vec_t v, input bit expect_rsp, output int acc);
        @(posedge clk);
        #1;
        drive_req(v);
        req_valid = 1'b1;
        acc = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = cyc + 1;
                break;
            end
        end
        if (acc < 0) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=no_accept required=accept");
        end else if (expect_rsp) begin
            sb.push_back('{v: v, acc: acc});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        // Junk on the request bus must not disturb the operation in flight.
        req_a = $urandom;
        req_b = $urandom;
        req_s = 4'($urandom);
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_outstanding", W'(sb.size()), '0);
        sb.delete();
    endtask

    initial begin
        int   acc;
        int   cnt;
        vec_t bp_old;
        vec_t bp_new;

        vt[0] = '{s: S_ADD, m: 1'b0, c_in: CARRY_NONE, a: 32'h000000FF, b: 32'h00000001,
                  f: 32'h00000100, c: 1'b1, eq: 1'b0};
        vt[1] = '{s: S_ADD, m: 1'b0, c_in: CARRY_NONE, a: 32'hFFFFFFFF, b: 32'h00000001,
                  f: 32'h00000000, c: 1'b0, eq: 1'b0};
        vt[2] = '{s: S_XOR, m: 1'b1, c_in: CARRY_NONE, a: 32'h12345678, b: 32'h0F0F0F0F,
                  f: 32'h1D3B5977, c: 1'b0, eq: 1'b0};
        vt[3] = '{s: S_SUB, m: 1'b0, c_in: CARRY_NONE, a: 32'hCAFEBABE, b: 32'hCAFEBABE,
                  f: 32'hFFFFFFFF, c: 1'b1, eq: 1'b1};
        vt[4] = '{s: S_SUB, m: 1'b0, c_in: CARRY_NONE, a: 32'hCAFEBABF, b: 32'hCAFEBABE,
                  f: 32'h00000000, c: 1'b0, eq: 1'b0};
        vt[5] = '{s: S_AND, m: 1'b1, c_in: CARRY_NONE, a: 32'hF0F0AAAA, b: 32'hFF00CC33,
                  f: 32'hF0008822, c: 1'b0, eq: 1'b0};
        vt[6] = '{s: S_ADD, m: 1'b0, c_in: 1'b0, a: 32'h00000001, b: 32'h00000002,
                  f: 32'h00000004, c: 1'b1, eq: 1'b0};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_s     = '0;
        req_m     = 1'b0;
        req_c_in  = 1'b1;
        rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", W'(req_ready), '0);
        chk("rst_rsp_valid", W'(rsp_valid), '0);
        chk("rst_rsp_f", rsp_f, '0);
        chk("rst_alu_a", W'(alu_a), '0);
        chk("rst_alu_s_m_cin", W'({alu_s, alu_m, alu_c_in}), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", W'(req_ready), W'(1));

        // First ADD, watching the carry ripple into byte 1
        send(vt[0], 1'b1, acc);
        @(negedge clk);
        chk("byte0_alu_a", W'(alu_a), W'(8'hFF));
        chk("byte0_alu_c_in", W'(alu_c_in), W'(1));
        chk("byte0_alu_s", W'(alu_s), W'(S_ADD));
        @(negedge clk);
        chk("byte1_alu_a", W'(alu_a), W'(8'h00));
        chk("byte1_alu_c_in", W'(alu_c_in), W'(0));
        drain();
        chk("idle_alu_b", W'(alu_b), '0);

        // Table: back-to-back requests with rsp_ready held high
        for (int i = 0; i < 7; i++) begin
            send(vt[i], 1'b1, acc);
        end
        drain();

        // Backpressure, then same-edge handoff to the next request
        bp_old = vt[3];
        bp_new = vt[4];
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        send(bp_old, 1'b1, acc);
        cnt = 0;
        while (!rsp_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("bp_rsp_valid_seen", W'(rsp_valid), W'(1));
        drive_req(bp_new);
        req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", W'(rsp_valid), W'(1));
            chk("bp_hold_f", rsp_f, bp_old.f);
            chk("bp_hold_flags", W'({rsp_c_out, rsp_a_eq_b}), W'({bp_old.c, bp_old.eq}));
            chk("bp_req_ready", W'(req_ready), '0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_handoff_ready", W'(req_ready), W'(1));
        sb.push_back('{v: bp_new, acc: cyc + 1});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("bp_new_byte0_a", W'(alu_a), W'(8'hBF));
        chk("bp_new_byte0_b", W'(alu_b), W'(8'hBE));
        drain();

        // Reset during byte 2 aborts the operation
        send(vt[1], 1'b0, acc);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req_ready", W'(req_ready), '0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_alu_a_b", W'({alu_a, alu_b}), '0);
        chk("abort_alu_s_m_cin", W'({alu_s, alu_m, alu_c_in}), '0);
        chk("abort_rsp_valid", W'(rsp_valid), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("abort_no_rsp", W'(cnt), '0);
        chk("abort_req_ready", W'(req_ready), W'(1));

        // Recovery after abort
        send(vt[5], 1'b1, acc);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
